renkon_feat_loader: RTL and testbench
=====================================

// Module: renkon_feat_loader
// PURPOSE
//  Upstream stage of the renkon feature memory. Accepts a stream of signed
//  feature words from the ninjin side through a valid/ready handshake and
//  writes them to consecutive feature-memory addresses starting at base_addr.
//  Drives the memory's write port 1 (we/addr/data); port 2 stays read-only.
//  Signals completion to the renkon controller with a one-cycle done pulse.
// PARAMETERS
//  DWIDTH  16  feature word width, signed
//  FACCUM  10  feature memory address width (2**FACCUM words)
// PORTS
//  clk         in   1       clock
//  xrst        in   1       reset, synchronous, active-low
//  req         in   1       start pulse; sampled only in IDLE
//  base_addr   in   FACCUM  first write address, latched on req
//  total_len   in   FACCUM+1 number of words to load (0..2**FACCUM)
//  s_valid     in   1       stream word valid
//  s_data      in   DWIDTH  stream word (signed)
//  s_ready     out  1       loader can accept s_data this cycle
//  mem_we      out  1       feature memory write enable
//  mem_addr    out  FACCUM  feature memory write address
//  write_data  out  DWIDTH  feature memory write data (signed)
//  busy        out  1       high from req accept until done pulse ends
//  done        out  1       one-cycle pulse after last write issued
// BEHAVIOUR
//  - Reset (xrst=0 at posedge): state=IDLE, s_ready=0, mem_we=0, mem_addr=0,
//    write_data=0, busy=0, done=0, counters=0. Reset mid-load abandons the
//    transfer; no further writes, no done pulse.
//  - FSM IDLE -> LOAD on req; LOAD -> FLUSH when the handshake for word
//    total_len-1 occurs; FLUSH -> DONE (write of last word visible);
//    DONE -> IDLE after one cycle (done=1 in DONE only).
//  - req with total_len=0: IDLE -> DONE directly; no write, done one cycle
//    after req. req while not IDLE is ignored.
//  - s_ready=1 only in LOAD. Handshake = s_valid & s_ready. s_valid may drop
//    at any time; gaps stall the counter, no write issued.
//  - Write latency 1: handshake at cycle t -> mem_we=1, mem_addr=base+k,
//    write_data=s_data at cycle t+1 (registered outputs), where k = count of
//    prior handshakes. mem_we is 0 in any cycle without a preceding handshake.
//  - Address arithmetic modulo 2**FACCUM: base_addr + k wraps from 2**FACCUM-1
//    to 0. total_len = 2**FACCUM fills the whole memory exactly once.
//  - busy=1 in LOAD, FLUSH, DONE; 0 in IDLE.
//  - req in the same cycle as DONE is ignored (not IDLE).
// CONFIGURATION
//  RENKON_FEAT_LOAD_RELU_EN defined: write_data = (s_data<0) ? 0 : s_data,
//  same latency. Undefined: write_data = s_data unmodified.
// STRUCTURE
//  - DWIDTH/FACCUM come from the shared headers (ninjin.vh, renkon.vh); the
//    FSM state encodings (S_IDLE, S_LOAD, S_FLUSH, S_DONE) go in renkon.vh.
//  - One sub-module: renkon_feat_addr_gen (load base, increment, wrap,
//    last-word compare against total_len-1).
// TESTING
//  1 Reset: hold xrst=0 3 cycles with s_valid=1 -> all outputs 0, no mem_we.
//  2 base=0x010,len=4, s_valid continuous, data 1,-2,3,-4 -> mem_we at 4
//    consecutive cycles, addr 0x010..0x013, done 2 cycles after 4th handshake;
//    with RENKON_FEAT_LOAD_RELU_EN data written 1,0,3,0.
//  3 base=0x3FE,len=4 -> addr 0x3FE,0x3FF,0x000,0x001.
//  4 len=3, s_valid pattern 1,0,0,1,0,1 -> exactly 3 writes, addr contiguous,
//    mem_we never high in a cycle following a non-handshake.
//  5 len=0 req -> done pulse next+1 cycle, mem_we stays 0; req during LOAD
//    with different base ignored (addresses unchanged).
//  6 Reset asserted after 2 of 8 words -> writes stop next cycle, no done;
//    new req afterwards loads from new base correctly.

Source files
------------

// File: rtl/renkon_feat_loader_pkg.sv
// ============================================================================
// Module      : renkon_feat_loader_pkg
// Description : Shared widths, FSM state encoding and data helpers for the
//               renkon feature-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package renkon_feat_loader_pkg;

    localparam int DWIDTH = 16;
    localparam int FACCUM = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Clamp negative feature words to zero (signed, two's complement)
    function automatic logic [DWIDTH-1:0] relu(input logic [DWIDTH-1:0] d);
        return d[DWIDTH-1] ? '0 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/renkon_feat_addr_gen.sv
// ============================================================================
// Module      : renkon_feat_addr_gen
// Description : Write-address generator: latches base/length, steps on each
//               accepted word, wraps modulo the memory size, flags last word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module renkon_feat_addr_gen
    import renkon_feat_loader_pkg::*;
(
    input  logic              clk,
    input  logic              xrst,
    input  logic              load,
    input  logic [FACCUM-1:0] base_addr,
    input  logic [FACCUM:0]   total_len,
    input  logic              inc,
    output logic [FACCUM-1:0] addr,
    output logic              last
);

    logic [FACCUM-1:0] r_base;
    logic [FACCUM:0]   r_len;
    logic [FACCUM:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_base <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_base <= base_addr;
            r_len  <= total_len;
            r_cnt  <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The FACCUM-bit sum wraps naturally from the top of memory back to 0
    assign addr = r_base + r_cnt[FACCUM-1:0];
    assign last = (r_cnt == (r_len - 1'b1));

endmodule

`default_nettype wire

// File: rtl/renkon_feat_loader.sv
// ============================================================================
// Module      : renkon_feat_loader
// Description : Streams signed feature words into consecutive feature-memory
//               addresses and pulses done after the last write.
//               Option macro RENKON_FEAT_LOAD_RELU_EN clamps negative words
//               to zero before they are written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module renkon_feat_loader
    import renkon_feat_loader_pkg::*;
(
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [FACCUM-1:0] base_addr,
    input  logic [FACCUM:0]   total_len,
    input  logic              s_valid,
    input  logic [DWIDTH-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [FACCUM-1:0] mem_addr,
    output logic [DWIDTH-1:0] write_data,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_hs;
    logic              w_last;
    logic [FACCUM-1:0] w_addr;
    logic [DWIDTH-1:0] w_data;

    assign w_accept = (r_state == S_IDLE) && req;
    assign w_hs     = s_valid && s_ready;

    assign s_ready  = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

`ifdef RENKON_FEAT_LOAD_RELU_EN
    assign w_data = relu(s_data);
`else
    assign w_data = s_data;
`endif

    renkon_feat_addr_gen u_addr_gen (
        .clk       (clk),
        .xrst      (xrst),
        .load      (w_accept),
        .base_addr (base_addr),
        .total_len (total_len),
        .inc       (w_hs),
        .addr      (w_addr),
        .last      (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req) w_next = (total_len == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (w_hs && w_last) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address/data hold their last value between writes; only mem_we qualifies them
    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_state    <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            write_data <= '0;
        end else begin
            r_state <= w_next;
            mem_we  <= w_hs;
            if (w_hs) begin
                mem_addr   <= w_addr;
                write_data <= w_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_renkon_feat_loader.sv
// ============================================================================
// Module      : tb_renkon_feat_loader
// Description : Self-checking bench for renkon_feat_loader against a
//               transaction-level model (word counter plus tail countdown).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_renkon_feat_loader;
    import renkon_feat_loader_pkg::*;

`ifdef RENKON_FEAT_LOAD_RELU_EN
    localparam bit c_relu = 1'b1;
`else
    localparam bit c_relu = 1'b0;
`endif
    localparam int c_mem_words = 1 << FACCUM;

    logic              clk;
    logic              xrst;
    logic              req;
    logic [FACCUM-1:0] base_addr;
    logic [FACCUM:0]   total_len;
    logic              s_valid;
    logic [DWIDTH-1:0] s_data;
    logic              s_ready;
    logic              mem_we;
    logic [FACCUM-1:0] mem_addr;
    logic [DWIDTH-1:0] write_data;
    logic              busy;
    logic              done;

    renkon_feat_loader dut (
        .clk        (clk),
        .xrst       (xrst),
        .req        (req),
        .base_addr  (base_addr),
        .total_len  (total_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: accepting words, words taken so far, and the number of
    // busy-but-not-accepting cycles left (done shows in the last of them).
    bit          m_acc  = 1'b0;
    int          m_k    = 0;
    int          m_len  = 0;
    int          m_base = 0;
    int          m_tail = 0;
    bit          e_we   = 1'b0;
    int          e_addr = 0;
    logic [15:0] e_data = '0;
    int          n_we   = 0;

    function automatic bit model_idle();
        return !m_acc && (m_tail == 0);
    endfunction

    task automatic step(input bit rst_n, input bit rq, input int base, input int len,
                        input bit v, input logic [DWIDTH-1:0] d);
        bit idle;
        bit hs;
        xrst      = rst_n;
        req       = rq;
        base_addr = FACCUM'(base);
        total_len = (FACCUM+1)'(len);
        s_valid   = v;
        s_data    = d;
        if (!rst_n) begin
            m_acc  = 1'b0;
            m_tail = 0;
            m_k    = 0;
            e_we   = 1'b0;
        end else begin
            idle = model_idle();
            hs   = m_acc && v;
            e_we = hs;
            if (hs) begin
                e_addr = (m_base + m_k) % c_mem_words;
                e_data = (c_relu && d[DWIDTH-1]) ? '0 : d;
                m_k++;
            end
            if (m_tail > 0) m_tail--;
            if (hs && m_k == m_len) begin
                m_acc  = 1'b0;
                m_tail = 2;
            end
            if (idle && rq) begin
                if (len == 0) begin
                    m_tail = 1;
                end else begin
                    m_acc  = 1'b1;
                    m_k    = 0;
                    m_base = base;
                    m_len  = len;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (mem_we === 1'b1) n_we++;
        check("s_ready", s_ready, m_acc);
        check("busy", busy, m_acc || (m_tail > 0));
        check("done", done, m_tail == 1);
        check("mem_we", mem_we, e_we);
        if (e_we) begin
            check("mem_addr", mem_addr, e_addr);
            check("write_data", write_data, e_data);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, '0);
    endtask

    int d2[4] = '{1, -2, 3, -4};
    int v4[6] = '{1, 0, 0, 1, 0, 1};

    initial begin
        xrst = 1'b0; req = 1'b0; base_addr = '0; total_len = '0;
        s_valid = 1'b0; s_data = '0;
        @(negedge clk);

        // Reset with s_valid high
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'($urandom));
        check("rst_mem_addr", mem_addr, 0);
        check("rst_write_data", write_data, 0);
        check("rst_mem_we", mem_we, 0);

        // Basic 4-word load with mixed-sign data
        n_we = 0;
        step(1, 1, 'h010, 4, 0, '0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 16'(d2[i]));
        idle_steps(4);
        check("load4_writes", n_we, 4);

        // Wrap across the top of memory
        n_we = 0;
        step(1, 1, 'h3FE, 4, 0, '0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 16'($urandom));
        idle_steps(4);
        check("wrap_writes", n_we, 4);

        // Gapped valid pattern
        n_we = 0;
        step(1, 1, 'h123, 3, 0, '0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, v4[i] != 0, 16'($urandom));
        idle_steps(4);
        check("gap_writes", n_we, 3);

        // Zero-length request, then req during LOAD with another base
        n_we = 0;
        step(1, 1, 'h050, 0, 0, '0);
        idle_steps(3);
        check("len0_writes", n_we, 0);
        step(1, 1, 'h100, 5, 0, '0);
        step(1, 0, 0, 0, 1, 16'($urandom));
        step(1, 1, 'h200, 2, 1, 16'($urandom));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 16'($urandom));
        idle_steps(4);
        check("midreq_writes", n_we, 5);

        // Reset mid-load, then a fresh load
        n_we = 0;
        step(1, 1, 'h050, 8, 0, '0);
        step(1, 0, 0, 0, 1, 16'($urandom));
        step(1, 0, 0, 0, 1, 16'($urandom));
        step(0, 0, 0, 0, 1, 16'($urandom));
        idle_steps(4);
        check("abort_writes", n_we, 2);
        step(1, 1, 'h080, 3, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 16'($urandom));
        idle_steps(4);
        check("reload_writes", n_we, 5);

        // Fill the whole memory exactly once
        n_we = 0;
        step(1, 1, 'h155, c_mem_words, 0, '0);
        for (int i = 0; i < c_mem_words; i++) step(1, 0, 0, 0, 1, 16'($urandom));
        idle_steps(4);
        check("full_writes", n_we, c_mem_words);

        // Randomized transactions with stray reqs, gaps and rare resets
        for (int t = 0; t < 40; t++) begin
            int guard;
            guard = 0;
            step(1, 1, $urandom_range(0, c_mem_words - 1), $urandom_range(0, 12), 0, '0);
            while (!model_idle() && guard < 500) begin
                step($urandom_range(0, 149) != 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, c_mem_words - 1), $urandom_range(0, 12),
                     $urandom_range(0, 2) != 0, 16'($urandom));
                guard++;
            end
            if (guard >= 500) check("timeout", 1, 0);
        end
        idle_steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
